// File: rtl/mult_share_ctrl_if.sv
// Request/result bundle between two clients, the shared multiplier scheduler and the downstream consumer.
interface mult_share_ctrl_if #(
    parameter int unsigned N = 4,
    parameter int unsigned M = 4
);
    logic             req0_valid;
    logic [N-1:0]     req0_a;
    logic [M-1:0]     req0_b;
    logic             req0_ready;
    logic             req1_valid;
    logic [N-1:0]     req1_a;
    logic [M-1:0]     req1_b;
    logic             req1_ready;
    logic             res_valid;
    logic             res_ready;
    logic [N+M-1:0]   res_data;
    logic             res_id;

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
        input  req0_ready, req1_ready, res_valid, res_data, res_id
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
        output req0_ready, req1_ready, res_valid, res_data, res_id
    );
endinterface

// File: rtl/mult_share_ctrl.sv
// Round-robin scheduler sharing one iterative shift-add multiplier between two requesters.
// Fixed M-cycle computation; the product is held until downstream accepts it.
module mult_share_ctrl #(
    parameter int unsigned N = 4,
    parameter int unsigned M = 4
) (
    input  logic             clk,
    input  logic             rstn,
    mult_share_ctrl_if.slave bus,
    output logic             busy
);
    localparam int unsigned W  = N + M;
    localparam int unsigned CW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state;
    logic            pri;
    logic            id;
    logic [W-1:0]    acc;
    logic [W-1:0]    a_sh;
    logic [M-1:0]    b_sh;
    logic [CW-1:0]   cnt;
    logic            res_valid;
    logic [W-1:0]    res_data;
    logic            res_id;

    logic            gnt_valid;
    logic            gnt_id;
    logic [N-1:0]    sel_a;
    logic [M-1:0]    sel_b;
    logic [W-1:0]    acc_step;

    // Grant only in IDLE; on contention the priority pointer decides.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = 1'b0;
        if (state == ST_IDLE) begin
            if (bus.req0_valid && bus.req1_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = pri;
            end else if (bus.req0_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b0;
            end else if (bus.req1_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b1;
            end
        end
    end

    assign sel_a    = gnt_id ? bus.req1_a : bus.req0_a;
    assign sel_b    = gnt_id ? bus.req1_b : bus.req0_b;
    assign acc_step = b_sh[0] ? (acc + a_sh) : acc;

    assign bus.req0_ready = gnt_valid && !gnt_id;
    assign bus.req1_ready = gnt_valid && gnt_id;
    assign bus.res_valid  = res_valid;
    assign bus.res_data   = res_data;
    assign bus.res_id     = res_id;
    assign busy           = (state != ST_IDLE);

    // Control FSM and datapath; CALC always runs exactly M steps.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            pri       <= 1'b0;
            id        <= 1'b0;
            acc       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            cnt       <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        acc   <= '0;
                        a_sh  <= W'(sel_a);
                        b_sh  <= sel_b;
                        cnt   <= '0;
                        id    <= gnt_id;
                        state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc  <= acc_step;
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(M - 1)) begin
                        state     <= ST_DONE;
                        res_valid <= 1'b1;
                        res_data  <= acc_step;
                        res_id    <= id;
                    end
                end
                ST_DONE: begin
                    if (bus.res_ready) begin
                        res_valid <= 1'b0;
                        pri       <= ~id;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_share_ctrl.sv
// Scoreboard bench for mult_share_ctrl: a transaction-level model predicts grants, timing and products.
module tb_mult_share_ctrl;
    localparam int unsigned N = 4;
    localparam int unsigned M = 4;
    localparam int unsigned W = N + M;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic busy;

    mult_share_ctrl_if #(.N(N), .M(M)) bus ();

    mult_share_ctrl #(.N(N), .M(M)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         id;
        logic [W-1:0] prod;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model: one operation in flight, result due M+1 sampling points after acceptance.
    bit m_busy = 1'b0;
    bit m_id   = 1'b0;
    bit m_pri  = 1'b0;
    int m_due  = 0;

    bit hs0 = 1'b0;
    bit hs1 = 1'b0;
    bit wd1 = 1'b0;
    int rr_mode = 1;

    bit g_v, g_id, exp_v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || m_busy || sb.size() != 0) && n < limit) begin
            step(1);
            n++;
        end
        checks++;
        if (n >= limit) begin
            failures++;
            $display("FAIL drain_timeout cycle=%0d pending q0=%0d q1=%0d sb=%0d", cyc, q0.size(), q1.size(), sb.size());
        end
        step(1);
    endtask

    // Monitor / scoreboard: sample mid-cycle, compare, then advance the model to the next edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rstn) begin
                chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
                chk("rst_res_data", 32'(bus.res_data), 32'd0);
                chk("rst_res_id", 32'(bus.res_id), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
                chk("rst_req1_ready", 32'(bus.req1_ready), 32'd0);
                m_busy = 1'b0;
                m_pri  = 1'b0;
                hs0    = 1'b0;
                hs1    = 1'b0;
                sb.delete();
            end else begin
                g_v  = 1'b0;
                g_id = 1'b0;
                if (!m_busy) begin
                    if (bus.req0_valid && bus.req1_valid) begin
                        g_v  = 1'b1;
                        g_id = m_pri;
                    end else if (bus.req0_valid) begin
                        g_v = 1'b1;
                    end else if (bus.req1_valid) begin
                        g_v  = 1'b1;
                        g_id = 1'b1;
                    end
                end
                exp_v = m_busy && (cyc >= m_due);
                chk("req0_ready", 32'(bus.req0_ready), 32'(g_v && !g_id));
                chk("req1_ready", 32'(bus.req1_ready), 32'(g_v && g_id));
                chk("busy", 32'(busy), 32'(m_busy));
                chk("res_valid", 32'(bus.res_valid), 32'(exp_v));
                if (bus.res_valid) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_result cycle=%0d got=%0h expected=none", cyc, bus.res_data);
                    end else begin
                        chk("res_data", 32'(bus.res_data), 32'(sb[0].prod));
                        chk("res_id", 32'(bus.res_id), 32'(sb[0].id));
                        if (bus.res_ready) void'(sb.pop_front());
                    end
                end
                hs0 = bus.req0_valid && bus.req0_ready;
                hs1 = bus.req1_valid && bus.req1_ready;
                if (exp_v && bus.res_ready) begin
                    m_busy = 1'b0;
                    m_pri  = ~m_id;
                end else if (g_v) begin
                    exp_t e;
                    int   pa, pb;
                    pa     = g_id ? int'(bus.req1_a) : int'(bus.req0_a);
                    pb     = g_id ? int'(bus.req1_b) : int'(bus.req0_b);
                    e.id   = g_id;
                    e.prod = W'(pa * pb);
                    sb.push_back(e);
                    m_busy = 1'b1;
                    m_id   = g_id;
                    m_due  = cyc + int'(M) + 1;
                end
            end
        end
    end

    // Requester and downstream driver: holds each pair until its handshake.
    initial begin
        bus.req0_valid = 1'b0;
        bus.req0_a     = '0;
        bus.req0_b     = '0;
        bus.req1_valid = 1'b0;
        bus.req1_a     = '0;
        bus.req1_b     = '0;
        bus.res_ready  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (hs0) begin
                if (q0.size() > 0) void'(q0.pop_front());
                hs0 = 1'b0;
            end
            if (hs1) begin
                if (q1.size() > 0) void'(q1.pop_front());
                hs1 = 1'b0;
            end
            if (q0.size() > 0) begin
                bus.req0_valid = 1'b1;
                {bus.req0_a, bus.req0_b} = q0[0];
            end else begin
                bus.req0_valid = 1'b0;
            end
            if (q1.size() > 0 && !wd1) begin
                bus.req1_valid = 1'b1;
                {bus.req1_a, bus.req1_b} = q1[0];
            end else begin
                bus.req1_valid = 1'b0;
            end
            case (rr_mode)
                0:       bus.res_ready = 1'b0;
                1:       bus.res_ready = 1'b1;
                default: bus.res_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        int n;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #2 rstn = 1'b1;
        step(1);

        // Single operation, downstream always ready.
        rr_mode = 1;
        q0.push_back({4'd13, 4'd11});
        wait_drain(40);

        // Point priority back at req0, then continuous contention.
        q1.push_back({4'd2, 4'd3});
        wait_drain(40);
        for (int i = 0; i < 3; i++) begin
            q0.push_back({4'd3, 4'd5});
            q1.push_back({4'd7, 4'd9});
        end
        wait_drain(100);

        // Boundary operands.
        q0.push_back({4'd0, 4'd15});
        q0.push_back({4'd15, 4'd0});
        q0.push_back({4'd15, 4'd15});
        q0.push_back({4'd1, 4'd1});
        wait_drain(100);

        // Backpressure with a competing request pending.
        rr_mode = 0;
        q0.push_back({4'd6, 4'd7});
        n = 0;
        while (!bus.res_valid && n < 20) begin
            step(1);
            n++;
        end
        chk("bp_res_valid_seen", 32'(bus.res_valid), 32'd1);
        q1.push_back({4'd2, 4'd5});
        step(5);
        rr_mode = 1;
        wait_drain(60);

        // Reset mid-calculation with priority pointing at req1 beforehand.
        q0.push_back({4'd1, 4'd3});
        wait_drain(40);
        q0.push_back({4'd9, 4'd9});
        n = 0;
        while (q0.size() != 0 && n < 20) begin
            step(1);
            n++;
        end
        chk("rst_op_accepted", 32'(q0.size()), 32'd0);
        step(2);
        rstn = 1'b0;
        step(2);
        rstn = 1'b1;
        step(1);
        q0.push_back({4'd2, 4'd3});
        q1.push_back({4'd5, 4'd5});
        wait_drain(60);

        // req1 valid withdrawn and reasserted while req0 is computing.
        q0.push_back({4'd4, 4'd4});
        n = 0;
        while (q0.size() != 0 && n < 20) begin
            step(1);
            n++;
        end
        q1.push_back({4'd3, 4'd3});
        step(1);
        wd1 = 1'b1;
        step(1);
        wd1 = 1'b0;
        wait_drain(60);

        // Randomized traffic and backpressure.
        rr_mode = 2;
        for (int i = 0; i < 30; i++) begin
            int sel;
            sel = int'($urandom_range(0, 2));
            if (sel != 1) q0.push_back(8'($urandom));
            if (sel != 0) q1.push_back(8'($urandom));
            step(int'($urandom_range(1, 8)));
        end
        wait_drain(3000);
        rr_mode = 1;

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mult_share_ctrl.md
# mult_share_ctrl

Two-requester scheduler for one shared iterative shift-add multiplier step. Round-robin arbitration picks one request, loads operands, then reuses a single shift-add stage for M cycles (test multiplier LSB, conditionally add multiplicand, shift both). It holds the product until downstream accepts it. It sits between two client blocks and the shared multiplier resource, so that one multiplier can serve both clients with a fixed latency.

## Interface
- N, 4, multiplicand width (a operands)
- M, 4, multiplier width (b operands); also the number of iteration cycles
- clk  in  1  clock; all state updates on rising edge
- rstn  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operand pair
- req0_a  in  N  requester 0 multiplicand
- req0_b  in  M  requester 0 multiplier
- req0_ready  out  1  requester 0 pair accepted this cycle when high with req0_valid
- req1_valid / req1_a / req1_b / req1_ready  same as requester 0, for requester 1
- res_valid  out  1  product available
- res_ready  in  1  downstream accepts the product
- res_data  out  N+M  unsigned product
- res_id  out  1  index of the requester that owns res_data
- busy  out  1  high whenever the state is not IDLE

## Operation
- FSM states: IDLE, CALC, DONE. Reset state is IDLE.
- Priority pointer `pri` (1 bit) resets to 0, which favours req0.
- IDLE:
  - grant is combinational: only one valid → grant that one; both valid → grant `pri`; none → no grant.
  - reqX_ready = (state==IDLE) && granted X. Never both high.
  - On the handshake edge: acc←0; a_sh←zero-extended reqX_a (N+M bits); b_sh←reqX_b; cnt←0; id←X; go to CALC.
- CALC, each cycle:
  - acc←acc+a_sh if b_sh[0]=1, else acc unchanged.
  - a_sh←a_sh<<1; b_sh←b_sh>>1; cnt←cnt+1.
  - On the step where cnt==M-1: go to DONE, res_valid←1, res_data←final acc, res_id←id.
  - The step count is always exactly M; there is no early exit when b_sh reaches 0.
- DONE:
  - res_valid, res_data and res_id are held stable until res_ready.
  - On the res_valid&&res_ready edge: res_valid←0, pri←~id, go to IDLE.
- Arithmetic is unsigned. An N+M-bit acc cannot overflow, and no carry is dropped.
- req ready is low in CALC and DONE. The requester must hold valid and operands until its handshake. Valid may drop before its handshake without side effects.
- res_ready is ignored outside DONE.

## Timing
- Reset values: req0_ready=0, req1_ready=0 (no request valid), res_valid=0, res_data=0, res_id=0, busy=0. Internal acc, a_sh, b_sh, cnt and id are also 0.
- Asynchronous reset in any state → IDLE immediately. Any in-flight operation is discarded, no res_valid is produced, and pri returns to 0.
- Latency: request handshake at edge k → res_valid high after edge k+M.
- Result handshake at edge j → state is IDLE after j, and the next request can handshake at edge j+1 at the earliest. No request is accepted on the same edge as a result handshake.
- Back-to-back throughput: one product per M+2 cycles with res_ready held high.
- busy rises after the request handshake edge and falls after the result handshake edge.
- Simultaneous valids in IDLE: `pri` decides. Once one requester is served, the other wins the next contention, so neither can be starved.
- If only the non-priority requester is valid, it is granted, and pri then points away from it.

## Test plan
- Reset, then req0 a=13 b=11 with res_ready=1 → req0_ready high 1 cycle; res_valid after 4 edges with res_data=8'h8F (143) and res_id=0; busy high for exactly 5 cycles.
- Both valid continuously, req0 (3×5), req1 (7×9) → order is id0 res 15, then id1 res 63, then id0 again. Grants alternate strictly, and each result is 6 cycles apart.
- Boundary operands: 0×15 → 0; 15×0 → 0; 15×15 → 225 (8'hE1); 1×1 → 1. Every case uses exactly M CALC cycles.
- Backpressure: 6×7 with res_ready low for 5 cycles after res_valid → res_data=42 and res_id are held stable. Both reqX_ready stay low even with req1_valid high. req1 is accepted on the edge after res_ready rises.
- Reset mid-CALC: rstn low 2 cycles after a 9×9 handshake → all outputs 0 and no res_valid. After release, a req1 5×5 completes with res 25, id 1, and priority restarts at req0.
- Valid withdrawn: req1_valid pulses low-high while in CALC for a req0 op → req1 is not captured early. req1 is accepted only in the next IDLE, and req1_ready is never high outside IDLE.
